// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit seven-segment display: blanked digit slots, scrolling message buffer.
// Optional digit blinking is compiled in when the BLINK_EN macro is defined.
module seg_scan_ctrl #(
    parameter int DIG_DIV    = 50000,
    parameter int BLANK_CYC  = 64,
    parameter int SCROLL_DIV = 200,
    parameter int MSG_LEN    = 16
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       msg_wr,
    input  logic [$clog2(MSG_LEN)-1:0] msg_addr,
    input  logic [7:0]                 msg_data,
    input  logic                       scroll_en,
`ifdef BLINK_EN
    input  logic [7:0]                 blink_mask,
`endif
    output logic [7:0]                 cathodes,
    output logic [7:0]                 anodes,
    output logic                       frame_tick
);
    localparam int AW = $clog2(MSG_LEN);
    localparam int PW = (DIG_DIV > 1) ? $clog2(DIG_DIV) : 1;
    localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(DIG_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);
    localparam logic [FW-1:0] FRM_LAST  = FW'(SCROLL_DIV - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    digit_q, digit_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [AW-1:0] offset_q, offset_d;
    logic [0:0]    state_q, state_d;
    logic [7:0]    anodes_q, anodes_d;
    logic [7:0]    cathodes_q, cathodes_d;
    logic          frame_tick_q, frame_tick_d;

    logic [7:0]    msg_buf_q [MSG_LEN];
    logic [7:0]    msg_buf_d [MSG_LEN];

    logic          slot_end;
    logic          frame_end;
    logic          drive_on;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;

`ifdef BLINK_EN
    // Own free-running frame count so the blink phase is independent of SCROLL_DIV.
    logic [4:0]    blink_cnt_q, blink_cnt_d;
    logic          blink_off;
`endif

    always_comb begin
        slot_end  = (presc_q == PRE_LAST);
        frame_end = slot_end && (digit_q == 3'd7);
        presc_d   = slot_end ? '0 : presc_q + 1'b1;
        digit_d   = slot_end ? digit_q + 3'd1 : digit_q;
        frame_d   = frame_q;
        offset_d  = offset_q;
        if (frame_end) begin
            if (frame_q == FRM_LAST) begin
                frame_d = '0;
                if (scroll_en) begin
                    offset_d = offset_q + 1'b1;
                end
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
        // State tracks the prescaler value it will sit beside after the edge.
        state_d = (presc_d < BLANK_END) ? ST_BLANK : ST_DRIVE;
    end

`ifdef BLINK_EN
    always_comb begin
        blink_cnt_d = frame_end ? blink_cnt_q + 5'd1 : blink_cnt_q;
        blink_off   = blink_mask[digit_q] && blink_cnt_q[4];
    end
`endif

    always_comb begin
        for (int i = 0; i < MSG_LEN; i++) begin
            msg_buf_d[i] = msg_buf_q[i];
            if (msg_wr && (msg_addr == AW'(i))) begin
                msg_buf_d[i] = msg_data;
            end
        end
    end

    always_comb begin
        rd_addr = offset_q + AW'(digit_q);
        rd_data = msg_buf_q[rd_addr];
`ifdef BLINK_EN
        drive_on = (state_q == ST_DRIVE) && !blink_off;
`else
        drive_on = (state_q == ST_DRIVE);
`endif
        anodes_d     = drive_on ? ~(8'b1 << digit_q) : 8'hFF;
        cathodes_d   = drive_on ? ~rd_data : 8'hFF;
        frame_tick_d = frame_end;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            presc_q      <= '0;
            digit_q      <= '0;
            frame_q      <= '0;
            offset_q     <= '0;
            state_q      <= ST_BLANK;
            anodes_q     <= 8'hFF;
            cathodes_q   <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            digit_q      <= digit_d;
            frame_q      <= frame_d;
            offset_q     <= offset_d;
            state_q      <= state_d;
            anodes_q     <= anodes_d;
            cathodes_q   <= cathodes_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_buf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_buf_q[i] <= msg_buf_d[i];
            end
        end
    end

`ifdef BLINK_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            blink_cnt_q <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
        end
    end
`endif

    assign anodes     = anodes_q;
    assign cathodes   = cathodes_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: cycle-level reference model plus directed literal checks.
module tb_seg_scan_ctrl;
    localparam int DIG_DIV    = 8;
    localparam int BLANK_CYC  = 2;
    localparam int SCROLL_DIV = 2;
    localparam int MSG_LEN    = 16;
    localparam int FRAME_CYC  = DIG_DIV * 8;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic       msg_wr = 1'b0;
    logic [3:0] msg_addr = '0;
    logic [7:0] msg_data = '0;
    logic       scroll_en = 1'b0;
`ifdef BLINK_EN
    logic [7:0] blink_mask = 8'h00;
`endif
    logic [7:0] cathodes;
    logic [7:0] anodes;
    logic       frame_tick;

    int errors = 0;
    int checks = 0;
    int ecount = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .DIG_DIV   (DIG_DIV),
        .BLANK_CYC (BLANK_CYC),
        .SCROLL_DIV(SCROLL_DIV),
        .MSG_LEN   (MSG_LEN)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .msg_wr    (msg_wr),
        .msg_addr  (msg_addr),
        .msg_data  (msg_data),
        .scroll_en (scroll_en),
`ifdef BLINK_EN
        .blink_mask(blink_mask),
`endif
        .cathodes  (cathodes),
        .anodes    (anodes),
        .frame_tick(frame_tick)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        ecount++;
    endtask

    // Reference model: position in the scan derived arithmetically from edges since reset.
    int         m_t = 0;
    int         m_frames = 0;
    int         m_off = 0;
    logic [7:0] m_buf [MSG_LEN];
    logic [7:0] e_an, e_cat;
    logic       e_ft;
    bit         have_exp = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (!nrst) begin
                m_t = 0;
                m_frames = 0;
                m_off = 0;
                for (int i = 0; i < MSG_LEN; i++) m_buf[i] = 8'h00;
                have_exp = 1'b0;
            end else begin
                int slot;
                int dig;
                slot = m_t % DIG_DIV;
                dig  = (m_t / DIG_DIV) % 8;
                if (slot < BLANK_CYC) begin
                    e_an  = 8'hFF;
                    e_cat = 8'hFF;
                end else begin
                    e_an  = ~(8'h01 << dig);
                    e_cat = ~m_buf[(m_off + dig) % MSG_LEN];
                end
                e_ft = ((m_t % FRAME_CYC) == FRAME_CYC - 1);
                if (e_ft) begin
                    m_frames++;
                    if ((m_frames % SCROLL_DIV) == 0 && scroll_en)
                        m_off = (m_off + 1) % MSG_LEN;
                end
                if (msg_wr) m_buf[msg_addr] = msg_data;
                m_t++;
                have_exp = 1'b1;
            end
            @(negedge clk);
            if (!nrst) begin
                chk("model_rst_anodes", anodes, 8'hFF);
                chk("model_rst_cathodes", cathodes, 8'hFF);
                chk("model_rst_tick", {7'b0, frame_tick}, 8'h00);
            end else if (have_exp) begin
                chk("model_anodes", anodes, e_an);
                chk("model_cathodes", cathodes, e_cat);
                chk("model_tick", {7'b0, frame_tick}, {7'b0, e_ft});
            end
        end
    end

    initial begin
        int ft_cnt;
        int waited;
        #1 nrst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_anodes", anodes, 8'hFF);
        chk("reset_cathodes", cathodes, 8'hFF);
        chk("reset_tick", {7'b0, frame_tick}, 8'h00);

        // Release reset while loading the first two entries.
        msg_wr = 1'b1; msg_addr = 4'd0; msg_data = 8'h3F;
        nrst = 1'b1; ecount = 0;
        tick();
        msg_addr = 4'd1; msg_data = 8'h06;
        tick();
        msg_wr = 1'b0;
        while (ecount < 16) begin
            tick();
            if (ecount == 3 || ecount == 8) begin
                chk("dig0_anodes", anodes, 8'hFE);
                chk("dig0_cathodes", cathodes, 8'hC0);
            end
            if (ecount == 9 || ecount == 10) begin
                chk("gap_anodes", anodes, 8'hFF);
                chk("gap_cathodes", cathodes, 8'hFF);
            end
            if (ecount == 11 || ecount == 16) begin
                chk("dig1_anodes", anodes, 8'hFD);
                chk("dig1_cathodes", cathodes, 8'hF9);
            end
        end

        ft_cnt = 0;
        while (ecount < 272) begin
            tick();
            if (frame_tick) ft_cnt++;
        end
        chk("tick_count", 8'(ft_cnt), 8'd4);

        scroll_en = 1'b1;
        while (ecount < 387) tick();
        chk("scroll1_anodes", anodes, 8'hFE);
        chk("scroll1_cathodes", cathodes, 8'hF9);

        scroll_en = 1'b0;
        while (ecount < 1027) tick();
        chk("frozen_cathodes", cathodes, 8'hF9);

        scroll_en = 1'b1;
        msg_wr = 1'b1; msg_addr = 4'd15; msg_data = 8'h5B;
        tick();
        msg_wr = 1'b0;
        while (ecount < 2819) tick();
        chk("off15_dig0_anodes", anodes, 8'hFE);
        chk("off15_dig0_cathodes", cathodes, 8'hA4);
        scroll_en = 1'b0;
        while (ecount < 2827) tick();
        chk("off15_dig1_anodes", anodes, 8'hFD);
        chk("off15_dig1_cathodes", cathodes, 8'hC0);

        // Overwrite the entry currently on display.
        msg_wr = 1'b1; msg_addr = 4'd0; msg_data = 8'h7F;
        tick();
        msg_wr = 1'b0;
        chk("wr_edge_old_value", cathodes, 8'hC0);
        tick();
        chk("wr_next_new_value", cathodes, 8'h80);

        repeat (3000) begin
            msg_wr   = 1'($urandom_range(0, 1));
            msg_addr = 4'($urandom_range(0, 15));
            msg_data = 8'($urandom);
            if ($urandom_range(0, 99) < 2) scroll_en = ~scroll_en;
            tick();
        end

        // Asynchronous reset mid-slot, ideally while a digit is driven.
        msg_wr = 1'b0;
        waited = 0;
        while (anodes === 8'hFF && waited < 64) begin
            tick();
            waited++;
        end
        checks++;
        if (anodes === 8'hFF) begin
            errors++;
            $display("FAIL find_drive: got %02h expected a driven digit within 64 cycles", anodes);
        end
        @(posedge clk);
        #2 nrst = 1'b0;
        #1;
        chk("async_rst_anodes", anodes, 8'hFF);
        chk("async_rst_cathodes", cathodes, 8'hFF);
        chk("async_rst_tick", {7'b0, frame_tick}, 8'h00);
        repeat (3) @(negedge clk);
        nrst = 1'b1; ecount = 0;
        repeat (3) tick();
        chk("post_rst_anodes", anodes, 8'hFE);
        chk("post_rst_cleared", cathodes, 8'hFF);
        repeat (100) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
